contador: RTL and testbench

CONTADOR -- requirements
Module: contador

---
 rtl/contador.sv | 27 ++
 tb/tb_contador.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/contador.sv
// rtl/contador.sv - free-running WIDTH-bit up counter with synchronous active-high clear
module contador #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over increment, so the all-ones value goes straight to zero.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        if (reset) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: tb/tb_contador.sv
// tb/tb_contador.sv - randomized self-checking bench for contador (WIDTH=5 and WIDTH=3)
module tb_contador;

    logic       clk;
    logic       rst5;
    logic       rst3;
    logic [4:0] count5;
    logic [2:0] count3;

    int total;
    int bad;
    int exp5;
    int exp3;
    int edge_no;

    contador #(.WIDTH(5)) dut5 (.clk(clk), .reset(rst5), .count_out(count5));
    contador #(.WIDTH(3)) dut3 (.clk(clk), .reset(rst3), .count_out(count3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reset clears, otherwise add one modulo 2^WIDTH; sampled just after each edge.
    task automatic tick();
        @(posedge clk);
        exp5 = rst5 ? 0 : (exp5 + 1) % 32;
        exp3 = rst3 ? 0 : (exp3 + 1) % 8;
        edge_no++;
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        rst5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count5 !== 5'd0) begin
                bad++;
                $display("FAIL reset_hold edge %0d: got %0d want 0", i, count5);
            end
        end
        rst5 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            e = exp5[4:0];
            total++;
            if (count5 !== e || count5 !== k[4:0]) begin
                bad++;
                $display("FAIL reset_release step %0d: got %0d want %0d", k, count5, k);
            end
        end
    endtask

    task automatic test_sweep();
        logic [4:0] e;
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            e = exp5[4:0];
            total++;
            if (count5 !== e) begin
                bad++;
                $display("FAIL sweep step %0d: got %0d want %0d", k, count5, e);
            end
        end
        total++;
        if (count5 !== 5'd0) begin
            bad++;
            $display("FAIL sweep_wrap: got %0d want 0", count5);
        end
    endtask

    task automatic test_reset_mid();
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        for (int k = 0; k < 17; k++) tick();
        total++;
        if (count5 !== 5'd17) begin
            bad++;
            $display("FAIL mid_reach17: got %0d want 17", count5);
        end
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        total++;
        if (count5 !== 5'd0) begin
            bad++;
            $display("FAIL mid_clear: got %0d want 0", count5);
        end
        tick();
        total++;
        if (count5 !== 5'd1) begin
            bad++;
            $display("FAIL mid_resume: got %0d want 1", count5);
        end
    endtask

    task automatic test_reset_terminal();
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        for (int k = 0; k < 31; k++) tick();
        total++;
        if (count5 !== 5'd31) begin
            bad++;
            $display("FAIL term_reach31: got %0d want 31", count5);
        end
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        total++;
        if (count5 !== 5'd0) begin
            bad++;
            $display("FAIL term_clear: got %0d want 0", count5);
        end
        tick();
        total++;
        if (count5 !== 5'd1) begin
            bad++;
            $display("FAIL term_next: got %0d want 1", count5);
        end
        tick();
        total++;
        if (count5 !== 5'd2) begin
            bad++;
            $display("FAIL term_next2: got %0d want 2", count5);
        end
    endtask

    task automatic test_periodic();
        int last24;
        int spans;
        int prev;
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        last24 = -1;
        spans = 0;
        prev = 0;
        for (int k = 0; k < 120; k++) begin
            rst5 = (count5 == 5'd24);
            tick();
            total++;
            if ((prev == 24 && count5 !== 5'd0) || (prev != 24 && count5 !== 5'(prev + 1))) begin
                bad++;
                $display("FAIL periodic_seq after %0d: got %0d", prev, count5);
            end
            if (count5 == 5'd24) begin
                if (last24 >= 0) begin
                    spans++;
                    total++;
                    if (edge_no - last24 + 1 != 26) begin
                        bad++;
                        $display("FAIL periodic_span: got %0d edges want 26", edge_no - last24 + 1);
                    end
                end
                last24 = edge_no;
            end
            prev = int'(count5);
        end
        rst5 = 1'b0;
        total++;
        if (spans < 3) begin
            bad++;
            $display("FAIL periodic_count: got %0d spans want >=3", spans);
        end
    endtask

    task automatic test_glitch();
        logic [4:0] e;
        rst5 = 1'b1;
        tick();
        rst5 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #2 rst5 = 1'b1;
            #2 rst5 = 1'b0;
            tick();
            e = exp5[4:0];
            total++;
            if (count5 !== e) begin
                bad++;
                $display("FAIL glitch step %0d: got %0d want %0d", k, count5, e);
            end
        end
    endtask

    task automatic test_width3();
        logic [2:0] e;
        rst3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count3 !== 3'd0) begin
                bad++;
                $display("FAIL w3_reset edge %0d: got %0d want 0", i, count3);
            end
        end
        rst3 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            e = exp3[2:0];
            total++;
            if (count3 !== e || count3 !== 3'(k % 8)) begin
                bad++;
                $display("FAIL w3_seq step %0d: got %0d want %0d", k, count3, k % 8);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e5;
        logic [2:0] e3;
        for (int k = 0; k < 400; k++) begin
            rst5 = ($urandom_range(0, 9) == 0);
            rst3 = ($urandom_range(0, 6) == 0);
            tick();
            e5 = exp5[4:0];
            e3 = exp3[2:0];
            total++;
            if (count5 !== e5) begin
                bad++;
                $display("FAIL random_w5 cycle %0d: got %0d want %0d", k, count5, e5);
            end
            total++;
            if (count3 !== e3) begin
                bad++;
                $display("FAIL random_w3 cycle %0d: got %0d want %0d", k, count3, e3);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp5 = 0;
        exp3 = 0;
        edge_no = 0;
        rst5 = 1'b1;
        rst3 = 1'b1;
        #1;
        test_reset();
        test_sweep();
        test_reset_mid();
        test_reset_terminal();
        test_periodic();
        test_glitch();
        test_width3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
